// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the hazard events coming from the pipeline and the stall/flush
//   controls going back to it, so the sequencer connects through one port.
//   Parameters:
//     REG_AW  register-address width
//     CNT_W   perf-counter width
//   Modports:
//     master  pipeline side: drives the hazard events, receives the controls
//     slave   hazard sequencer: receives the events, drives the controls
//   Signals (direction as seen from the sequencer):
//     in : id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
//          branch_taken_i, icache_stall_i, dcache_stall_i
//     out: pc_write_o, pc_redirect_o, if_id/id_ex/ex_mem stall,
//          if_id/id_ex/mem_wb flush, state_o, stall_cnt_o, bubble_cnt_o
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs_i;
   logic [REG_AW-1:0] id_rt_i;
   logic              id_uses_rt_i;
   logic              ex_memread_i;
   logic [REG_AW-1:0] ex_rd_i;
   logic              branch_taken_i;
   logic              icache_stall_i;
   logic              dcache_stall_i;

   logic              pc_write_o;
   logic              pc_redirect_o;
   logic              if_id_stall_o;
   logic              id_ex_stall_o;
   logic              ex_mem_stall_o;
   logic              if_id_flush_o;
   logic              id_ex_flush_o;
   logic              mem_wb_flush_o;
   logic [1:0]        state_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
             branch_taken_i, icache_stall_i, dcache_stall_i,
      input  pc_write_o, pc_redirect_o, if_id_stall_o, id_ex_stall_o,
             ex_mem_stall_o, if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
             state_o, stall_cnt_o, bubble_cnt_o
   );

   modport slave (
      input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
             branch_taken_i, icache_stall_i, dcache_stall_i,
      output pc_write_o, pc_redirect_o, if_id_stall_o, id_ex_stall_o,
             ex_mem_stall_o, if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
             state_o, stall_cnt_o, bubble_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Produces the PC
//   write-enable and per-register stall/flush controls from load-use, branch,
//   icache-miss and dcache-miss events. A branch redirect that resolves while
//   an icache miss is outstanding is remembered and replayed once the miss
//   ends. Owns no datapath.
//   Ports:
//     clk_i  clock, all state on posedge
//     rst_i  asynchronous, active-low reset
//     bus    pipe_hazard_ctrl_if.slave (hazard events in, controls out)
//   Optional feature macro: HAZ_PERF_CNT_EN
//     defined  : stall_cnt_o / bubble_cnt_o are saturating cycle counters
//     undefined: both counter outputs tied to zero, no counter flops
//   Controls are Mealy (current state + current inputs). While rst_i is low
//   the PC is held and every pipeline register is flushed.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   pipe_hazard_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DSTALL = 2'd1,
      ISTALL = 2'd2,
      REPLAY = 2'd3
   } state_t;

   state_t state_r;
   state_t state_nxt_s;
   logic   br_pend_r;
   logic   br_pend_nxt_s;
   logic   lu_s;

   logic   pc_write_s;
   logic   pc_redirect_s;
   logic   if_id_stall_s;
   logic   id_ex_stall_s;
   logic   ex_mem_stall_s;
   logic   if_id_flush_s;
   logic   id_ex_flush_s;
   logic   mem_wb_flush_s;

   // Load in EX writing a register the ID instruction reads; r0 never hazards.
   assign lu_s = bus.ex_memread_i
               & (bus.ex_rd_i != {REG_AW{1'b0}})
               & ((bus.ex_rd_i == bus.id_rs_i)
                  | (bus.id_uses_rt_i & (bus.ex_rd_i == bus.id_rt_i)));

   // State and pending-branch registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r   <= RUN;
         br_pend_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         br_pend_r <= br_pend_nxt_s;
      end
   end

   // Next-state and control decode, priority dcache > icache > replay > load-use > branch.
   always_comb begin
      state_nxt_s    = RUN;
      br_pend_nxt_s  = br_pend_r;
      pc_write_s     = 1'b1;
      pc_redirect_s  = 1'b0;
      if_id_stall_s  = 1'b0;
      id_ex_stall_s  = 1'b0;
      ex_mem_stall_s = 1'b0;
      if_id_flush_s  = 1'b0;
      id_ex_flush_s  = 1'b0;
      mem_wb_flush_s = 1'b0;
      if (!rst_i) begin
         pc_write_s     = 1'b0;
         if_id_flush_s  = 1'b1;
         id_ex_flush_s  = 1'b1;
         mem_wb_flush_s = 1'b1;
         br_pend_nxt_s  = 1'b0;
      end else if (bus.dcache_stall_i) begin
         // Freeze everything up to MEM; the branch in ID re-asserts on release.
         pc_write_s     = 1'b0;
         if_id_stall_s  = 1'b1;
         id_ex_stall_s  = 1'b1;
         ex_mem_stall_s = 1'b1;
         mem_wb_flush_s = 1'b1;
         state_nxt_s    = DSTALL;
      end else if (bus.icache_stall_i) begin
         pc_write_s    = 1'b1 & 1'b0;
         if_id_flush_s = 1'b1;
         state_nxt_s   = ISTALL;
         if (bus.branch_taken_i) begin
            br_pend_nxt_s = 1'b1;
         end else begin
            br_pend_nxt_s = br_pend_r;
         end
      end else if (br_pend_r) begin
         // Miss over with a saved redirect: drop the wrong-path fetch, load the target.
         pc_redirect_s = 1'b1;
         if_id_flush_s = 1'b1;
         br_pend_nxt_s = 1'b0;
         state_nxt_s   = REPLAY;
      end else if (lu_s) begin
         pc_write_s    = 1'b0;
         if_id_stall_s = 1'b1;
         id_ex_flush_s = 1'b1;
      end else if (bus.branch_taken_i) begin
         if_id_flush_s = 1'b1;
      end else begin
         state_nxt_s = RUN;
      end
   end

   assign bus.pc_write_o     = pc_write_s;
   assign bus.pc_redirect_o  = pc_redirect_s;
   assign bus.if_id_stall_o  = if_id_stall_s;
   assign bus.id_ex_stall_o  = id_ex_stall_s;
   assign bus.ex_mem_stall_o = ex_mem_stall_s;
   assign bus.if_id_flush_o  = if_id_flush_s;
   assign bus.id_ex_flush_o  = id_ex_flush_s;
   assign bus.mem_wb_flush_o = mem_wb_flush_s;
   assign bus.state_o        = state_r;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] bubble_cnt_r;

   // Saturating counters of PC-hold cycles and ID_EX bubble cycles.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_r  <= {CNT_W{1'b0}};
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (!pc_write_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (id_ex_flush_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
      end
   end

   assign bus.stall_cnt_o  = stall_cnt_r;
   assign bus.bubble_cnt_o = bubble_cnt_r;
`else
   assign bus.stall_cnt_o  = {CNT_W{1'b0}};
   assign bus.bubble_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios followed by random traffic, each cycle compared with a
//   reference model that classifies the cycle into a named event and looks up
//   the expected control pattern for that event.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (hif.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int m_mode   = 0;   // 0 run, 1 dcache freeze, 2 icache wait, 3 replay
   bit m_pend   = 1'b0;
   int m_stall  = 0;
   int m_bubble = 0;

   // One clock: drive at negedge, check just after, advance model for the posedge.
   task automatic apply(input bit rst, input bit mr, input int rd, input int rs,
                        input int rt, input bit urt, input bit br, input bit ic, input bit dc);
      string ev;
      bit lu;
      logic [7:0] e;
      logic [7:0] o;
      logic [1:0] es;
      logic [CNT_W-1:0] ec;
      @(negedge clk_i);
      rst_i              = rst;
      hif.ex_memread_i   = mr;
      hif.ex_rd_i        = REG_AW'(rd);
      hif.id_rs_i        = REG_AW'(rs);
      hif.id_rt_i        = REG_AW'(rt);
      hif.id_uses_rt_i   = urt;
      hif.branch_taken_i = br;
      hif.icache_stall_i = ic;
      hif.dcache_stall_i = dc;
      #1;
      lu = mr && (rd != 0) && ((rd == rs) || (urt && rd == rt));
      if (!rst) begin
         m_mode = 0; m_pend = 1'b0; m_stall = 0; m_bubble = 0;
         ev = "reset";
      end else if (dc)     ev = "dmiss";
      else if (ic)         ev = "imiss";
      else if (m_pend)     ev = "replay";
      else if (lu)         ev = "loaduse";
      else if (br)         ev = "branch";
      else                 ev = "run";
      // {pc_write, redirect, if_id_st, id_ex_st, ex_mem_st, if_id_fl, id_ex_fl, mem_wb_fl}
      case (ev)
         "reset":   e = 8'b0000_0111;
         "dmiss":   e = 8'b0011_1001;
         "imiss":   e = 8'b0000_0100;
         "replay":  e = 8'b1100_0100;
         "loaduse": e = 8'b0010_0010;
         "branch":  e = 8'b1000_0100;
         default:   e = 8'b1000_0000;
      endcase
      o = {hif.pc_write_o, hif.pc_redirect_o, hif.if_id_stall_o, hif.id_ex_stall_o,
           hif.ex_mem_stall_o, hif.if_id_flush_o, hif.id_ex_flush_o, hif.mem_wb_flush_o};
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL ctl_%s observed=%b expected=%b", ev, o, e);
      end
      es = 2'(m_mode);
      n_vec++;
      assert (hif.state_o === es) else begin
         n_err++;
         $error("FAIL state_%s observed=%0d expected=%0d", ev, hif.state_o, es);
      end
      ec = CNT_W'(m_stall);
      n_vec++;
      assert (hif.stall_cnt_o === ec) else begin
         n_err++;
         $error("FAIL stall_cnt observed=%0d expected=%0d", hif.stall_cnt_o, ec);
      end
      ec = CNT_W'(m_bubble);
      n_vec++;
      assert (hif.bubble_cnt_o === ec) else begin
         n_err++;
         $error("FAIL bubble_cnt observed=%0d expected=%0d", hif.bubble_cnt_o, ec);
      end
      if (rst) begin
`ifdef HAZ_PERF_CNT_EN
         if (!e[7] && m_stall < CMAX)  m_stall++;
         if (e[1]  && m_bubble < CMAX) m_bubble++;
`endif
         case (ev)
            "dmiss":  m_mode = 1;
            "imiss":  begin m_mode = 2; if (br) m_pend = 1'b1; end
            "replay": begin m_mode = 3; m_pend = 1'b0; end
            default:  m_mode = 0;
         endcase
      end
   endtask

   initial begin
      hif.ex_memread_i = 1'b0; hif.ex_rd_i = '0; hif.id_rs_i = '0; hif.id_rt_i = '0;
      hif.id_uses_rt_i = 1'b0; hif.branch_taken_i = 1'b0;
      hif.icache_stall_i = 1'b0; hif.dcache_stall_i = 1'b0;
      // reset state
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use on rs, single bubble, then rt path with and without uses_rt
      apply(1, 1, 5, 5, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 5, 0, 0, 0, 0, 0);
      apply(1, 1, 7, 1, 7, 1, 0, 0, 0);
      apply(1, 1, 7, 1, 7, 0, 0, 0, 0);
      // load to r0 never stalls
      apply(1, 1, 0, 0, 0, 1, 0, 0, 0);
      // load-use with a branch in the same cycle: branch ignored
      apply(1, 1, 3, 3, 0, 0, 1, 0, 0);
      // dcache miss 4 cycles with load-use and branch concurrent, then release
      repeat (4) apply(1, 1, 4, 4, 0, 0, 1, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // icache miss with branch, 3 cycles, then replay and run
      apply(1, 0, 0, 0, 0, 0, 1, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // icache miss without branch releases straight to run
      apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // plain taken branch
      apply(1, 0, 0, 0, 0, 0, 1, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // reset in the middle of an icache miss with a pending branch
      apply(1, 0, 0, 0, 0, 0, 1, 1, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 9) < 4),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 2),
               ($urandom_range(0, 9) < 2),
               ($urandom_range(0, 9) < 1));
      end
      // long dcache miss drives the stall counter into saturation, then reset clears it
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (20) apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
